// File: rtl/circle_hex_driver.sv
// Drives six 7-segment displays with a moving head segment and a PWM-dimmed tail,
// sampled from an upstream circle index generator one cycle after each step pulse.
module circle_hex_driver #(
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned TAIL_DUTY = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    input  logic [2:0]  row_index_i,
    input  logic        column_index_i,
    input  logic [1:0]  trail_len_i,
    input  logic        blank_i,
    output logic [47:0] hex_o,
    output logic        err_o
);

    localparam int unsigned HEX_W      = 48;
    localparam int unsigned ENTRY_W    = 4;
    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned DUTY_W     = PWM_BITS + 1;
    localparam logic [2:0]  MAX_ROW    = 3'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIST_DEPTH);

    logic                                step_d;
    logic [HIST_DEPTH-1:0][ENTRY_W-1:0]  hist;
    logic [CNT_W-1:0]                    cnt;
    logic [PWM_BITS-1:0]                 pwm_cnt;
    logic                                sample_ok_c;
    logic                                sample_bad_c;
    logic                                tail_on_c;
    logic [HEX_W-1:0]                    hex_c;

    // Entry {column,row} -> bit position: row r on HEX(5-r), column 0 = seg a, 1 = seg d
    function automatic logic [5:0] seg_idx(input logic [ENTRY_W-1:0] e);
        seg_idx = 6'((5 - int'(e[2:0])) * 8 + (e[3] ? 3 : 0));
    endfunction

    assign sample_ok_c  = step_d && (row_index_i <= MAX_ROW);
    assign sample_bad_c = step_d && (row_index_i >  MAX_ROW);
    assign tail_on_c    = (DUTY_W'(pwm_cnt) < DUTY_W'(TAIL_DUTY));

    // Step delay, history shift, fill count, PWM and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_d  <= 1'b0;
            hist    <= '0;
            cnt     <= '0;
            pwm_cnt <= '0;
            err_o   <= 1'b0;
        end else begin
            step_d  <= step_i;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (sample_ok_c) begin
                hist <= {hist[HIST_DEPTH-2:0], {column_index_i, row_index_i}};
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (sample_bad_c) begin
                err_o <= 1'b1;
            end
        end
    end

    // Display image; head is applied unconditionally so it wins over a coinciding tail
    always_comb begin
        hex_c = '1;
        if (!blank_i) begin
            for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
                if (tail_on_c && (2'(k) <= trail_len_i) && (CNT_W'(k) < cnt)) begin
                    hex_c[seg_idx(hist[2'(k)])] = 1'b0;
                end
            end
            if (cnt != '0) begin
                hex_c[seg_idx(hist[0])] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hex_o <= '1;
        end else begin
            hex_o <= hex_c;
        end
    end

endmodule

// File: tb/tb_circle_hex_driver.sv
// Scoreboard bench for circle_hex_driver: a queue-based history model predicts each
// output cycle, a negedge monitor pops and compares.
module tb_circle_hex_driver;

    localparam int unsigned PWM_BITS  = 4;
    localparam int unsigned TAIL_DUTY = 4;
    localparam logic [47:0] ALL_DARK  = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  row = 3'd0;
    logic        col = 1'b0;
    logic [1:0]  trail = 2'd0;
    logic        blank = 1'b0;
    logic [47:0] hex;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [48:0] exp_q[$];

    circle_hex_driver #(.PWM_BITS(PWM_BITS), .TAIL_DUTY(TAIL_DUTY)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .step_i         (step),
        .row_index_i    (row),
        .column_index_i (col),
        .trail_len_i    (trail),
        .blank_i        (blank),
        .hex_o          (hex),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples kept newest-first in a queue of at most four entries
    logic [3:0] m_hist[$];
    logic       m_step_d = 1'b0;
    int         m_pwm = 0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        logic [47:0] eh;
        int idx;
        if (!rst_n) begin
            m_hist.delete();
            m_step_d = 1'b0;
            m_pwm    = 0;
            m_err    = 1'b0;
            exp_q.push_back({ALL_DARK, 1'b0});
        end else begin
            eh = ALL_DARK;
            if (!blank) begin
                for (int k = 0; k < m_hist.size(); k++) begin
                    if (k == 0 || (k <= int'(trail) && m_pwm < int'(TAIL_DUTY))) begin
                        idx = 8 * (5 - int'(m_hist[k][2:0])) + (m_hist[k][3] ? 3 : 0);
                        eh[idx] = 1'b0;
                    end
                end
            end
            if (m_step_d) begin
                if (row <= 3'd5) begin
                    m_hist.push_front({col, row});
                    if (m_hist.size() > 4) void'(m_hist.pop_back());
                end else begin
                    m_err = 1'b1;
                end
            end
            m_step_d = step;
            m_pwm    = (m_pwm + 1) % (1 << PWM_BITS);
            exp_q.push_back({eh, m_err});
        end
    end

    // Monitor: one prediction per clock; async reset overrides the prediction
    always @(negedge clk) begin
        logic [48:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_n) begin
                chk("hex_reset", hex, ALL_DARK);
                chk("err_reset", 48'(err), 48'd0);
            end else begin
                chk("hex", hex, e[48:1]);
                chk("err", 48'(err), 48'(e[0]));
            end
        end
    end

    task automatic drive(input logic s, input logic [2:0] r, input logic c);
        step = s;
        row  = r;
        col  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n, input bit allow_bad);
        for (int i = 0; i < n; i++) begin
            if (i % 40 == 0) trail = 2'($urandom_range(0, 3));
            blank = ($urandom_range(0, 15) == 0);
            if (allow_bad && $urandom_range(0, 19) == 0)
                drive($urandom_range(0, 2) == 0, 3'($urandom_range(6, 7)), 1'($urandom));
            else
                drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 5)), 1'($urandom));
        end
        blank = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: display stays dark
        repeat (100) drive(1'b0, 3'd0, 1'b0);
        chk("idle_dark", hex, ALL_DARK);
        chk("idle_err", 48'(err), 48'd0);

        // Single step row 0 upper, no tail: HEX5 segment a only
        trail = 2'd0;
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        chk("first_head", hex, 48'hFEFF_FFFF_FFFF);

        // Full circle with three tail positions, back-to-back steps
        trail = 2'd3;
        for (int i = 0; i < 12; i++)
            drive(1'b1, 3'(i < 6 ? i : 11 - i), 1'(i >= 6));
        repeat (40) drive(1'b0, 3'd0, 1'b1);

        // Row 5 lower as head: HEX0 segment d
        drive(1'b1, 3'd5, 1'b1);
        drive(1'b0, 3'd5, 1'b1);
        trail = 2'd0;
        drive(1'b0, 3'd5, 1'b1);
        chk("row5_lower", hex, 48'hFFFF_FFFF_FFF7);

        // Blank during motion; samples keep flowing
        trail = 2'd3;
        blank = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 3'(i), 1'b0);
        chk("blank_dark", hex, ALL_DARK);
        blank = 1'b0;
        repeat (20) drive(1'b0, 3'd0, 1'b0);

        rand_phase(800, 1'b0);

        // Illegal row sets sticky error without disturbing history
        drive(1'b1, 3'd6, 1'b0);
        drive(1'b0, 3'd6, 1'b0);
        chk("err_set", 48'(err), 48'd1);
        repeat (10) drive(1'b0, 3'd0, 1'b0);
        chk("err_sticky", 48'(err), 48'd1);

        rand_phase(800, 1'b1);

        // Reset between steps clears immediately; next step shows head only
        trail = 2'd3;
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b0, 3'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_hex", hex, ALL_DARK);
        chk("rst_async_err", 48'(err), 48'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) drive(1'b0, 3'd0, 1'b0);
        chk("post_rst_dark", hex, ALL_DARK);
        drive(1'b1, 3'd2, 1'b1);
        drive(1'b0, 3'd2, 1'b1);
        drive(1'b0, 3'd2, 1'b1);
        chk("post_rst_head", hex, 48'hFFFF_F7FF_FFFF);
        repeat (20) drive(1'b0, 3'd0, 1'b0);

        rand_phase(400, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
